// File: rtl/color_sequencer.sv
// rtl/color_sequencer.sv - colour ROM sequencer: manual/auto palette walk, capture and valid pulse
// Optional build macro PING_PONG_EN: auto walk bounces between FIRST_CODE and LAST_CODE instead of wrapping.
module color_sequencer #(
    parameter logic [3:0] FIRST_CODE = 4'd15,
    parameter logic [3:0] LAST_CODE  = 4'd6,
    parameter int         DWELL      = 50_000_000,
    parameter int         CNT_W      = 26
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  SW,
    input  logic        MODE,
    input  logic        PAUSE,
    input  logic        STEP,
    output logic [3:0]  rom_sel,
    input  logic [23:0] rom_color,
    output logic [23:0] color,
    output logic        color_valid
);

    typedef enum logic [1:0] {
        ST_MANUAL     = 2'd0,
        ST_AUTO_RUN   = 2'd1,
        ST_AUTO_PAUSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t             state_q, state_d;
    logic [3:0]         sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               step_q;
    logic               load_d;
    logic               load1_q, load2_q;
    logic [23:0]        color_q;
    logic               valid_q;
    logic               step_rise;
    logic [3:0]         adv_code;

`ifdef PING_PONG_EN
    logic               dir_up_q, dir_up_d;
    logic               adv_dir_up;

    // Bounce at either end of the palette range; direction flips on the turning step.
    always_comb begin
        adv_code   = sel_q - 4'd1;
        adv_dir_up = dir_up_q;
        if (dir_up_q) begin
            if (sel_q == FIRST_CODE) begin
                adv_code   = sel_q - 4'd1;
                adv_dir_up = 1'b0;
            end else begin
                adv_code   = sel_q + 4'd1;
                adv_dir_up = 1'b1;
            end
        end else begin
            if (sel_q == LAST_CODE) begin
                adv_code   = sel_q + 4'd1;
                adv_dir_up = 1'b1;
            end else begin
                adv_code   = sel_q - 4'd1;
                adv_dir_up = 1'b0;
            end
        end
    end
`else
    always_comb begin
        adv_code = (sel_q == LAST_CODE) ? FIRST_CODE : (sel_q - 4'd1);
    end
`endif

    assign step_rise = STEP & ~step_q;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        load_d   = 1'b0;
`ifdef PING_PONG_EN
        dir_up_d = dir_up_q;
`endif
        case (state_q)
            ST_MANUAL: begin
                if (MODE) begin
                    state_d  = PAUSE ? ST_AUTO_PAUSE : ST_AUTO_RUN;
                    sel_d    = FIRST_CODE;
                    cnt_d    = '0;
                    load_d   = 1'b1;
`ifdef PING_PONG_EN
                    dir_up_d = 1'b0;
`endif
                end else if (SW != sel_q) begin
                    sel_d  = SW;
                    load_d = 1'b1;
                end
            end
            ST_AUTO_RUN: begin
                if (!MODE) begin
                    state_d = ST_MANUAL;
                    sel_d   = SW;
                    cnt_d   = '0;
                    load_d  = 1'b1;
                end else if (PAUSE) begin
                    state_d = ST_AUTO_PAUSE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    sel_d    = adv_code;
                    load_d   = 1'b1;
`ifdef PING_PONG_EN
                    dir_up_d = adv_dir_up;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_AUTO_PAUSE: begin
                // Counter stays frozen here so resuming finishes the interrupted dwell.
                if (!MODE) begin
                    state_d = ST_MANUAL;
                    sel_d   = SW;
                    cnt_d   = '0;
                    load_d  = 1'b1;
                end else if (!PAUSE) begin
                    state_d = ST_AUTO_RUN;
                end else if (step_rise) begin
                    sel_d    = adv_code;
                    load_d   = 1'b1;
`ifdef PING_PONG_EN
                    dir_up_d = adv_dir_up;
`endif
                end
            end
            default: begin
                state_d = ST_MANUAL;
            end
        endcase
    end

    // Two-stage load tracker: ROM registers one edge after rom_sel, we capture the edge after.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_MANUAL;
            sel_q    <= FIRST_CODE;
            cnt_q    <= '0;
            step_q   <= 1'b0;
            load1_q  <= 1'b0;
            load2_q  <= 1'b0;
            color_q  <= 24'h000000;
            valid_q  <= 1'b0;
`ifdef PING_PONG_EN
            dir_up_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            step_q   <= STEP;
            load1_q  <= load_d;
            load2_q  <= load1_q;
            valid_q  <= load2_q;
            if (load2_q) begin
                color_q <= rom_color;
            end
`ifdef PING_PONG_EN
            dir_up_q <= dir_up_d;
`endif
        end
    end

    assign rom_sel     = sel_q;
    assign color       = color_q;
    assign color_valid = valid_q;

endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
- Controller for the 24-bit colour ROM (4-bit code in, registered 24-bit colour out, 1-cycle latency, black on reset/unused codes).
- Drives the ROM's code input either from the board switches (manual) or from an internal dwell-timed palette walker (auto), with pause and single-step.
- Captures the ROM result into its own output register and flags each new colour with a one-cycle valid pulse for the downstream RGB/PWM driver.

Parameters:
- FIRST_CODE, 4'd15, first palette code visited in auto mode
- LAST_CODE, 4'd6, last palette code before wrap; FIRST_CODE > LAST_CODE required
- DWELL, 50_000_000, clock cycles each colour is held in auto run; minimum 2
- CNT_W, 26, dwell counter width; must satisfy 2^CNT_W >= DWELL

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous reset, active-low
- SW  in  4  manual colour code
- MODE  in  1  0 = manual, 1 = auto (level, synchronous to CLK)
- PAUSE  in  1  auto mode only: 1 holds current colour
- STEP  in  1  auto-pause only: rising edge advances one code
- rom_sel  out  4  registered code driven to ROM
- rom_color  in  24  ROM registered output
- color  out  24  captured colour
- color_valid  out  1  one-cycle pulse, color just updated

Behaviour:
- Interface decided: one clock CLK; RST synchronous, active-low.
- Reset (RST=0 at an edge): rom_sel=FIRST_CODE, color=24'h000000, color_valid=0, dwell counter=0, STEP edge register=0, load pipeline cleared, state=MANUAL. In-flight loads are discarded; no color_valid after reset.
- States: MANUAL, AUTO_RUN, AUTO_PAUSE. Evaluated per edge, priority order: reset > MODE change > PAUSE > STEP/dwell expiry.
- MANUAL: if SW != rom_sel, rom_sel<=SW and issue load. MODE=1 -> AUTO_RUN (or AUTO_PAUSE if PAUSE=1), rom_sel<=FIRST_CODE, counter<=0, issue load.
- AUTO_RUN: counter increments each cycle; at DWELL-1 counter<=0, advance code, issue load. PAUSE=1 -> AUTO_PAUSE, counter held (not cleared). MODE=0 -> MANUAL, rom_sel<=SW, issue load, counter<=0.
- AUTO_PAUSE: counter frozen; STEP rising edge (STEP=1, previous sample 0) advances code and issues load, counter unchanged. PAUSE=0 -> AUTO_RUN, resuming counter from held value. STEP ignored outside AUTO_PAUSE; STEP held high advances once.
- Advance: code decrements by 1; from LAST_CODE wraps to FIRST_CODE.
- Load pipeline: load issued at edge N (rom_sel updated at N); ROM registers at N+1; at N+2 color<=rom_color and color_valid=1 for the following cycle only. Fixed latency 2 edges from rom_sel change to color update. Back-to-back loads each complete independently; color_valid may be high on consecutive cycles.
- A load is issued only when rom_sel changes value or on mode entry; re-selecting same code in MANUAL issues nothing.
- ROM reset coupling: ROM and this block share RST, so color holds black after reset until first load.

Optional Feature:
- Macro PING_PONG_EN.
- Defined: auto walk reverses direction at ends instead of wrapping: FIRST_CODE down to LAST_CODE, then increments back up to FIRST_CODE, repeat; direction flag resets to "down" on reset and on every auto-mode entry; STEP follows current direction.
- Undefined: wrap behaviour as above; no direction register synthesised.

Test Plan:
- Reset then MODE=0, SW=4'b1110 -> rom_sel=4'hE next edge, color=24'hFF0000 two edges later, exactly one color_valid pulse.
- MODE=0, SW=4'b0011 (unused code) -> color=24'h000000 with one color_valid pulse; SW held -> no further pulses.
- DWELL=4, MODE=1, PAUSE=0 -> rom_sel sequence F,E,D,...,6,F every 4 cycles; colours FFFFFF, FF0000, 00FF00, ..., AAAAAA; wrap 6->F (PING_PONG_EN: 6->7).
- Auto, PAUSE=1 mid-dwell, STEP pulsed twice with STEP held 3 cycles each -> exactly two advances; PAUSE=0 -> next advance after remaining held dwell count.
- MODE 1->0 while a load is in flight -> in-flight colour delivered, then SW colour delivered; two valid pulses, final color matches SW.
- RST=0 asserted one cycle after a load issue -> no color_valid, color=0, rom_sel=FIRST_CODE, state MANUAL.
